// File: rtl/run_controller_if.sv
// Run-controller bus: host control/verdict signals plus the snooped core store port.
// master = run_controller side, slave = host/bench/stub-core side.
interface run_controller_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    // Host control
    logic              start;
    logic [DATA_W-1:0] expect_data;

    // Core snoop
    logic [ADDR_W-1:0] pc;
    logic              memwrite;
    logic [ADDR_W-1:0] aluout;
    logic [DATA_W-1:0] writedata;
    logic              core_reset;

    // Verdict
    logic              busy;
    logic              done;
    logic              pass;
    logic [1:0]        fail_code;
    logic [CNT_W-1:0]  cycle_count;

    // Store-address trace readout
    logic [1:0]        trace_idx;
    logic [ADDR_W-1:0] trace_addr;

    modport master (
        input  start,
        input  expect_data,
        input  pc,
        input  memwrite,
        input  aluout,
        input  writedata,
        input  trace_idx,
        output core_reset,
        output busy,
        output done,
        output pass,
        output fail_code,
        output cycle_count,
        output trace_addr
    );

    modport slave (
        output start,
        output expect_data,
        output pc,
        output memwrite,
        output aluout,
        output writedata,
        output trace_idx,
        input  core_reset,
        input  busy,
        input  done,
        input  pass,
        input  fail_code,
        input  cycle_count,
        input  trace_addr
    );
endinterface

// File: rtl/run_controller.sv
// Run-control harness for the single-cycle MIPS core: reset sequencing, cycle counting and
// done-store / stall / timeout verdicts. Optional store trace buffer under RUN_CTRL_TRACE_EN.
module run_controller #(
    parameter int unsigned       RST_CYCLES  = 4,
    parameter int unsigned       TIMEOUT     = 1024,
    parameter int unsigned       STALL_LIMIT = 16,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter logic [ADDR_W-1:0] DONE_ADDR   = ADDR_W'(32'h0000_0054),
    parameter int unsigned       CNT_W       = 16
) (
    input logic               clk_i,
    input logic               rst_ni,
    run_controller_if.master  bus_io
);

    localparam int unsigned HoldW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);

    localparam logic [HoldW-1:0]  HoldLast  = HoldW'(RST_CYCLES - 1);
    localparam logic [StallW-1:0] StallLast = StallW'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0]  CntLast   = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] CodeNone    = 2'b00;
    localparam logic [1:0] CodeData    = 2'b01;
    localparam logic [1:0] CodeStall   = 2'b10;
    localparam logic [1:0] CodeTimeout = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StResetHold,
        StRun,
        StPass,
        StFail
    } state_e;

    state_e              state_q, state_d;
    logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [StallW-1:0]   stall_cnt_q, stall_cnt_d;
    logic [ADDR_W-1:0]   last_pc_q, last_pc_d;
    logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
    logic [1:0]          fail_code_q, fail_code_d;
    logic                core_reset_q, core_reset_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    logic                enter_hold;
    logic                done_store;
    logic                pc_same;

    assign done_store = bus_io.memwrite && (bus_io.aluout == DONE_ADDR);
    assign pc_same    = (bus_io.pc == last_pc_q);

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        stall_cnt_d = stall_cnt_q;
        last_pc_d   = last_pc_q;
        cycle_cnt_d = cycle_cnt_q;
        fail_code_d = fail_code_q;
        enter_hold  = 1'b0;

        unique case (state_q)
            StIdle: begin
                enter_hold = bus_io.start;
            end

            StResetHold: begin
                // Track pc while the core is held so the first RUN cycle compares against it.
                last_pc_d = bus_io.pc;
                if (hold_cnt_q == HoldLast) begin
                    state_d = StRun;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            StRun: begin
                last_pc_d = bus_io.pc;
                if (cycle_cnt_q != {CNT_W{1'b1}}) begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
                stall_cnt_d = pc_same ? stall_cnt_q + 1'b1 : '0;

                if (done_store) begin
                    if (bus_io.writedata == bus_io.expect_data) begin
                        state_d = StPass;
                    end else begin
                        state_d     = StFail;
                        fail_code_d = CodeData;
                    end
                end else if (pc_same && (stall_cnt_q == StallLast)) begin
                    state_d     = StFail;
                    fail_code_d = CodeStall;
                end else if (cycle_cnt_q == CntLast) begin
                    state_d     = StFail;
                    fail_code_d = CodeTimeout;
                end
            end

            StPass, StFail: begin
                enter_hold = bus_io.start;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (enter_hold) begin
            state_d     = StResetHold;
            hold_cnt_d  = '0;
            stall_cnt_d = '0;
            cycle_cnt_d = '0;
            fail_code_d = CodeNone;
        end

        // Outputs are registered from the next state so the verdict lands with the state.
        core_reset_d = (state_d != StRun);
        busy_d       = (state_d == StResetHold) || (state_d == StRun);
        done_d       = (state_d == StPass) || (state_d == StFail);
        pass_d       = (state_d == StPass);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            hold_cnt_q   <= '0;
            stall_cnt_q  <= '0;
            last_pc_q    <= '0;
            cycle_cnt_q  <= '0;
            fail_code_q  <= CodeNone;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            last_pc_q    <= last_pc_d;
            cycle_cnt_q  <= cycle_cnt_d;
            fail_code_q  <= fail_code_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign bus_io.core_reset  = core_reset_q;
    assign bus_io.busy        = busy_q;
    assign bus_io.done        = done_q;
    assign bus_io.pass        = pass_q;
    assign bus_io.fail_code   = fail_code_q;
    assign bus_io.cycle_count = cycle_cnt_q;

`ifdef RUN_CTRL_TRACE_EN
    logic [ADDR_W-1:0] trace_q [4];
    logic [1:0]        wrptr_q;
    logic [1:0]        rd_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) begin
                trace_q[i] <= '0;
            end
            wrptr_q <= '0;
        end else if (enter_hold) begin
            // Cleared entries double as the "empty reads 0" marker.
            for (int i = 0; i < 4; i++) begin
                trace_q[i] <= '0;
            end
            wrptr_q <= '0;
        end else if ((state_q == StRun) && bus_io.memwrite) begin
            trace_q[wrptr_q] <= bus_io.aluout;
            wrptr_q          <= wrptr_q + 2'd1;
        end
    end

    assign rd_ptr            = wrptr_q - 2'd1 - bus_io.trace_idx;
    assign bus_io.trace_addr = trace_q[rd_ptr];
`else
    logic unused_trace_idx;
    assign unused_trace_idx  = ^bus_io.trace_idx;
    assign bus_io.trace_addr = '0;
`endif

endmodule
